// File: rtl/crack_sched.sv
// crack_sched: splits the key space into 2^CHUNK_W-key chunks and dispatches them to NUM_WORKERS crack engines.
// Optional CRACK_SCHED_PERF_EN adds the perf_cycles/perf_chunks counters.

module crack_sched_lane #(
  parameter int KEY_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic             done,
  input  logic [KEY_W-1:0] base_in,
  output logic             busy,
  output logic [KEY_W-1:0] base
);
  // A dispatch wins over a clear so the first chunk can be issued on the accept edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      base <= '0;
    end else if (load) begin
      busy <= 1'b1;
      base <= base_in;
    end else if (clr || done) begin
      busy <= 1'b0;
    end
  end
endmodule

module crack_sched #(
  parameter int NUM_WORKERS = 2,
  parameter int KEY_W       = 24,
  parameter int CHUNK_W     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  output logic                         rdy,
  output logic [KEY_W-1:0]             key,
  output logic                         key_valid,
  output logic [NUM_WORKERS-1:0]       wk_start,
  output logic [NUM_WORKERS*KEY_W-1:0] wk_base,
  output logic                         wk_abort,
  input  logic [NUM_WORKERS-1:0]       wk_done,
  input  logic [NUM_WORKERS-1:0]       wk_found,
  input  logic [NUM_WORKERS*KEY_W-1:0] wk_key
`ifdef CRACK_SCHED_PERF_EN
  ,
  output logic [31:0]                  perf_cycles,
  output logic [KEY_W-CHUNK_W:0]       perf_chunks
`endif
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [KEY_W:0] CHUNK = {{KEY_W{1'b0}}, 1'b1} << CHUNK_W;

  state_t                              state;
  logic   [KEY_W:0]                    next_base;
  logic                                found_q;
  logic   [NUM_WORKERS-1:0]            busy, hit, pick, load;
  logic   [NUM_WORKERS-1:0][KEY_W-1:0] base_q, wkey;
  logic   [KEY_W-1:0]                  hit_key, disp_base;
  logic                                accept, clr, can_disp;

  assign wkey    = wk_key;
  assign wk_base = base_q;
  assign hit     = busy & wk_done & wk_found;
  // Isolate the lowest clear bit of the busy mask.
  assign pick    = ~busy & (busy + NUM_WORKERS'(1));
  assign accept  = (state == S_IDLE) && en;
  assign clr     = accept || ((state == S_RUN) && (|hit));
  assign can_disp = (state == S_RUN) && !(|hit) && !next_base[KEY_W] && (|pick);
  assign disp_base = accept ? '0 : next_base[KEY_W-1:0];

  always_comb begin
    load = '0;
    if (accept)        load[0] = 1'b1;
    else if (can_disp) load    = pick;
  end

  always_comb begin
    hit_key = '0;
    for (int i = NUM_WORKERS - 1; i >= 0; i--)
      if (hit[i]) hit_key = wkey[i];
  end

  for (genvar i = 0; i < NUM_WORKERS; i++) begin : g_lane
    crack_sched_lane #(.KEY_W(KEY_W)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr),
      .load    (load[i]),
      .done    (wk_done[i]),
      .base_in (disp_base),
      .busy    (busy[i]),
      .base    (base_q[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      rdy       <= 1'b1;
      key       <= '0;
      key_valid <= 1'b0;
      wk_start  <= '0;
      wk_abort  <= 1'b0;
      next_base <= '0;
      found_q   <= 1'b0;
    end else begin
      wk_start <= load;
      wk_abort <= 1'b0;
      case (state)
        S_IDLE: if (en) begin
          state     <= S_RUN;
          rdy       <= 1'b0;
          key       <= '0;
          key_valid <= 1'b0;
          found_q   <= 1'b0;
          next_base <= CHUNK;
        end
        S_RUN: begin
          if (|hit) begin
            key      <= hit_key;
            wk_abort <= 1'b1;
            found_q  <= 1'b1;
            state    <= S_DONE;
          end else begin
            if (can_disp) next_base <= next_base + CHUNK;
            if (next_base[KEY_W] && (busy == '0)) state <= S_DONE;
          end
        end
        S_DONE: begin
          key_valid <= found_q;
          rdy       <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef CRACK_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles <= '0;
      perf_chunks <= '0;
    end else if (accept) begin
      perf_cycles <= '0;
      perf_chunks <= (KEY_W-CHUNK_W+1)'(1);
    end else begin
      if ((state == S_RUN) && !(&perf_cycles)) perf_cycles <= perf_cycles + 32'd1;
      if (|load) perf_chunks <= perf_chunks + (KEY_W-CHUNK_W+1)'(1);
    end
  end
`endif
endmodule
